// File: rtl/score_window_sequencer.sv
// Streams song ROM notes into a WINDOW-deep look-ahead window, one note per tempo beat.
// Optional feature macro SCORE_LOOP_EN: seamless song looping (loop input, loop_count output).
module score_window_sequencer #(
  parameter int NOTE_W  = 4,
  parameter int WINDOW  = 16,
  parameter int ADDR_W  = 8,
  parameter int SONG_W  = 2,
  parameter int TEMPO_W = 26,
  parameter logic [NOTE_W-1:0] END_CODE  = {NOTE_W{1'b1}},
  parameter logic [NOTE_W-1:0] REST_CODE = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SONG_W-1:0]        song_id,
  input  logic [TEMPO_W-1:0]       tempo_in,
  input  logic                     pause,
  output logic [SONG_W-1:0]        rom_song,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [NOTE_W-1:0]        rom_data,
`ifdef SCORE_LOOP_EN
  input  logic                     loop,
  output logic [7:0]               loop_count,
`endif
  output logic [NOTE_W*WINDOW-1:0] window_out,
  output logic                     beat,
  output logic [ADDR_W-1:0]        note_index,
  output logic                     busy,
  output logic                     song_done
);

  localparam int WIN_W = NOTE_W * WINDOW;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_BEAT, DRAIN, DONE} state_t;

  state_t             state;
  logic [TEMPO_W-1:0] period;
  logic [TEMPO_W-1:0] cnt;
  logic [NOTE_W-1:0]  prefetch;
  logic               fetch_ph;
  logic               end_seen;

  logic               running;
  logic               beat_int;
  logic               shift_en;
  logic               pre_end;
  logic               loop_now;
  logic               loop_evt;
  logic               reach_end;
  logic [NOTE_W-1:0]  ins_note;
  logic [WIN_W-1:0]   shifted;

  // Periods below 4 would let a beat land inside the 2-cycle fetch.
  function automatic logic [TEMPO_W-1:0] clamp_period(input logic [TEMPO_W-1:0] t);
    return (t < TEMPO_W'(4)) ? TEMPO_W'(4) : t;
  endfunction

  function automatic logic [WIN_W-1:0] shift_in(input logic [WIN_W-1:0] w,
                                                input logic [NOTE_W-1:0] n);
    logic [WIN_W-1:0] r;
    r = w >> NOTE_W;
    r[WIN_W-1 -: NOTE_W] = n;
    return r;
  endfunction

  // The last ROM address terminates the song rather than wrapping to address 0.
  function automatic logic [NOTE_W-1:0] wrap_guard(input logic [ADDR_W-1:0] a,
                                                   input logic [NOTE_W-1:0] d);
    return ((a == {ADDR_W{1'b1}}) && (d != END_CODE)) ? END_CODE : d;
  endfunction

`ifdef SCORE_LOOP_EN
  assign loop_now = loop;
`else
  assign loop_now = 1'b0;
`endif

  always_comb begin
    running   = (state == FETCH) || (state == WAIT_BEAT) || (state == DRAIN);
    beat_int  = (cnt == period - TEMPO_W'(1));
    shift_en  = !start && !pause && beat_int && ((state == WAIT_BEAT) || (state == DRAIN));
    pre_end   = (prefetch == END_CODE);
    loop_evt  = (state == WAIT_BEAT) && pre_end && loop_now;
    ins_note  = ((state == WAIT_BEAT) && !loop_evt) ? prefetch : REST_CODE;
    shifted   = shift_in(window_out, ins_note);
    reach_end = (shifted[NOTE_W-1:0] == END_CODE) &&
                (end_seen || ((state == WAIT_BEAT) && pre_end && !loop_now));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      window_out <= {WINDOW{REST_CODE}};
      rom_addr   <= '0;
      rom_song   <= '0;
      note_index <= '0;
      cnt        <= '0;
      period     <= TEMPO_W'(4);
      fetch_ph   <= 1'b0;
      end_seen   <= 1'b0;
      beat       <= 1'b0;
      busy       <= 1'b0;
      song_done  <= 1'b0;
    end else if (start) begin
      state      <= FETCH;
      window_out <= {WINDOW{REST_CODE}};
      rom_addr   <= '0;
      rom_song   <= song_id;
      note_index <= '0;
      cnt        <= '0;
      period     <= clamp_period(tempo_in);
      fetch_ph   <= 1'b0;
      end_seen   <= 1'b0;
      beat       <= 1'b0;
      busy       <= 1'b1;
      song_done  <= 1'b0;
    end else begin
      beat <= shift_en;
      if (running && !pause)
        cnt <= beat_int ? '0 : cnt + TEMPO_W'(1);
      // Fetch: phase 0 presents rom_addr, phase 1 sees its data.
      if (state == FETCH) begin
        fetch_ph <= !fetch_ph;
        if (fetch_ph) begin
          rom_addr <= rom_addr + ADDR_W'(1);
          state    <= WAIT_BEAT;
        end
      end
      if (shift_en) begin
        window_out <= shifted;
        if (loop_evt) begin
          rom_addr   <= '0;
          note_index <= '0;
        end else if (state == WAIT_BEAT) begin
          note_index <= note_index + ADDR_W'(1);
        end
        if ((state == WAIT_BEAT) && pre_end && !loop_now)
          end_seen <= 1'b1;
        if (reach_end) begin
          state     <= DONE;
          busy      <= 1'b0;
          song_done <= 1'b1;
        end else if ((state == DRAIN) || (pre_end && !loop_now)) begin
          state <= DRAIN;
        end else begin
          state <= FETCH;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !start && (state == FETCH) && fetch_ph)
      prefetch <= wrap_guard(rom_addr, rom_data);
  end

`ifdef SCORE_LOOP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      loop_count <= '0;
    else if (shift_en && loop_evt && (loop_count != 8'hFF))
      loop_count <= loop_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_score_window_sequencer.sv
// Randomized bench for score_window_sequencer against a beat-count/note-sequence reference model.
module tb_score_window_sequencer;
  localparam int NOTE_W  = 4;
  localparam int WINDOW  = 16;
  localparam int ADDR_W  = 3;
  localparam int SONG_W  = 2;
  localparam int TEMPO_W = 26;
  localparam int DEPTH   = 1 << ADDR_W;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     start = 1'b0;
  logic                     pause = 1'b0;
  logic [SONG_W-1:0]        song_id = '0;
  logic [TEMPO_W-1:0]       tempo_in = '0;
  logic [SONG_W-1:0]        rom_song;
  logic [ADDR_W-1:0]        rom_addr;
  logic [NOTE_W-1:0]        rom_data;
  logic [NOTE_W*WINDOW-1:0] window_out;
  logic                     beat;
  logic [ADDR_W-1:0]        note_index;
  logic                     busy;
  logic                     song_done;
`ifdef SCORE_LOOP_EN
  logic                     loop = 1'b0;
  logic [7:0]               loop_count;
`endif

  score_window_sequencer #(
    .NOTE_W(NOTE_W), .WINDOW(WINDOW), .ADDR_W(ADDR_W), .SONG_W(SONG_W), .TEMPO_W(TEMPO_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .song_id(song_id), .tempo_in(tempo_in),
    .pause(pause), .rom_song(rom_song), .rom_addr(rom_addr), .rom_data(rom_data),
`ifdef SCORE_LOOP_EN
    .loop(loop), .loop_count(loop_count),
`endif
    .window_out(window_out), .beat(beat), .note_index(note_index), .busy(busy),
    .song_done(song_done)
  );

  always #5 clk = ~clk;

  logic [NOTE_W-1:0] rom [4][DEPTH];
  always @(posedge clk) rom_data <= rom[rom_song][rom_addr];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: song = notes up to the first END (address wrap forces END),
  // beat k happens on the k*P-th unpaused cycle after start.
  bit                m_run, m_done, m_beat, m_loop, m_fresh;
  int                m_k, m_a, m_p, m_len, m_lc;
  logic [SONG_W-1:0] m_song;
  logic [NOTE_W-1:0] m_seq [DEPTH];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NOTE_W-1:0] ins_note(input int j);
    int idx;
    if (m_loop) begin
      idx = (j - 1) % m_len;
      return (idx < m_len - 1) ? m_seq[idx] : 4'h0;
    end
    return (j <= m_len) ? m_seq[j-1] : 4'h0;
  endfunction

  function automatic logic [63:0] exp_window();
    logic [63:0] w;
    int j;
    w = '0;
    for (int i = 0; i < WINDOW; i++) begin
      j = m_k - (WINDOW - 1 - i);
      if (j >= 1) w[i*NOTE_W +: NOTE_W] = ins_note(j);
    end
    return w;
  endfunction

  task automatic model_start();
    logic [NOTE_W-1:0] n;
    m_run = 1; m_done = 0; m_k = 0; m_a = 0; m_fresh = 1;
    m_p = (tempo_in < 4) ? 4 : int'(tempo_in);
    m_song = song_id;
`ifdef SCORE_LOOP_EN
    m_loop = loop;
`else
    m_loop = 0;
`endif
    m_len = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (m_len == 0) begin
        n = rom[song_id][a];
        if (a == DEPTH - 1 && n != 4'hF) n = 4'hF;
        m_seq[a] = n;
        if (n == 4'hF) m_len = a + 1;
      end
    end
  endtask

  task automatic model_step();
    m_beat = 0; m_fresh = 0;
    if (reset) begin
      m_run = 0; m_done = 0; m_k = 0; m_a = 0; m_song = '0; m_loop = 0; m_lc = 0; m_len = 0;
    end else if (start) begin
      model_start();
    end else if (m_run && !pause) begin
      m_a++;
      if (m_a % m_p == 0) begin
        m_k++;
        m_beat = 1;
        if (m_loop) begin
          if (m_k % m_len == 0 && m_lc < 255) m_lc++;
        end else if (m_k == m_len + WINDOW - 1) begin
          m_run = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    int idx;
    idx = m_loop ? (m_k % m_len) : ((m_k < m_len) ? m_k : m_len);
    check_eq("window", window_out, exp_window());
    check_eq("beat", 64'(beat), 64'(m_beat));
    check_eq("note_index", 64'(note_index), 64'(idx % DEPTH));
    check_eq("busy", 64'(busy), 64'(m_run));
    check_eq("song_done", 64'(song_done), 64'(m_done));
    check_eq("rom_song", 64'(rom_song), 64'(m_song));
    if (m_fresh) check_eq("rom_addr_start", 64'(rom_addr), 64'd0);
    if (m_done) check_eq("rom_addr_end", 64'(rom_addr), 64'(m_len % DEPTH));
`ifdef SCORE_LOOP_EN
    check_eq("loop_count", 64'(loop_count), 64'(m_lc));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic begin_song(input int s, input int t);
    song_id = SONG_W'(s);
    tempo_in = TEMPO_W'(t);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int limit, input bit allow_open);
    int g;
    g = 0;
    while (!m_done && g < limit) begin
      step();
      g++;
    end
    if (!allow_open && !m_done) check_eq("song_timeout", 64'(song_done), 64'd1);
  endtask

  initial begin
    int cyc, nb;
    bit lp;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < DEPTH; a++) rom[s][a] = 4'h0;

    // Reset state
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(2);
    check_eq("reset_rom_addr", 64'(rom_addr), 64'd0);

    // Basic song 1,2,3,F at tempo 10
    rom[2][0] = 4'h1; rom[2][1] = 4'h2; rom[2][2] = 4'h3; rom[2][3] = 4'hF;
    begin_song(2, 10);
    cyc = 0;
    while (!m_done && cyc < 400) begin
      step();
      cyc++;
    end
    check_eq("done_cycle", 64'(cyc), 64'd190);
    check_eq("slot0_end", 64'(window_out[3:0]), 64'hF);
    run(20);

    // Tempo clamp: tempo 1 behaves as period 4
    begin_song(2, 1);
    nb = 0;
    repeat (40) begin
      step();
      if (beat) nb++;
    end
    check_eq("clamp_beats", 64'(nb), 64'd10);

    // Pause mid-song, then finish
    pause = 1'b1;
    run(25);
    pause = 1'b0;
    run_to_done(400, 0);

    // Song without END: last address forced to END
    for (int a = 0; a < DEPTH; a++) rom[1][a] = NOTE_W'(a + 1);
    begin_song(1, 4);
    run_to_done(400, 0);
    check_eq("wrap_slot0", 64'(window_out[3:0]), 64'hF);

    // Restart on a cycle that would otherwise beat
    rom[0][0] = 4'h7; rom[0][1] = 4'hF;
    begin_song(2, 6);
    cyc = 0;
    while ((m_k < 2 || (m_a + 1) % m_p != 0) && cyc < 200) begin
      step();
      cyc++;
    end
    begin_song(0, 5);
    run_to_done(400, 0);

    // Asynchronous reset mid-song
    begin_song(2, 10);
    run(35);
    #2 reset = 1'b1;
    #1;
    check_eq("async_window", window_out, 64'd0);
    check_eq("async_rom_addr", 64'(rom_addr), 64'd0);
    check_eq("async_busy", 64'(busy), 64'd0);
    step();
    reset = 1'b0;
    run(3);

`ifdef SCORE_LOOP_EN
    // Looping song 1,2,F
    rom[3][0] = 4'h1; rom[3][1] = 4'h2; rom[3][2] = 4'hF;
    loop = 1'b1;
    begin_song(3, 4);
    run(32);
    check_eq("loop_two_passes", 64'(loop_count), 64'd2);
    loop = 1'b0;
`endif

    // Randomized songs, tempos and pause patterns
    for (int it = 0; it < 10; it++) begin
      int s;
      s = $urandom_range(3);
      for (int a = 0; a < DEPTH; a++) rom[s][a] = NOTE_W'($urandom_range(15));
      lp = 0;
`ifdef SCORE_LOOP_EN
      lp = (it % 4 == 3);
      loop = lp;
`endif
      begin_song(s, $urandom_range(9));
      if (lp) begin
        repeat (300) begin
          if ($urandom_range(9) == 0) pause = ~pause;
          step();
        end
      end else begin
        cyc = 0;
        while (!m_done && cyc < 2000) begin
          if ($urandom_range(9) == 0) pause = ~pause;
          step();
          cyc++;
        end
        if (!m_done) check_eq("rand_timeout", 64'(song_done), 64'd1);
      end
      pause = 1'b0;
      run(5);
    end
`ifdef SCORE_LOOP_EN
    loop = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/score_window_sequencer.md
Name: score_window_sequencer

Overview:
Parametrised successor to the single-song note loader. Streams note codes from an external song ROM into a WINDOW-deep look-ahead shift window, one note per tempo beat. Tempo is per-song and run-time loaded; supports start/restart, pause, and clean end-of-song draining. Sits between the song ROM bank and the video note-highway renderer and scoring logic.

Parameters:
NOTE_W, 4, bits per note code
WINDOW, 16, number of visible note slots
ADDR_W, 8, ROM address width (max song length 2^ADDR_W)
SONG_W, 2, song select width
TEMPO_W, 26, beat period counter width
END_CODE, all-ones of NOTE_W, end-of-song marker
REST_CODE, 0, rest/filler note

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: load song_id/tempo_in, begin song
song_id  in  SONG_W  song select, sampled on start
tempo_in  in  TEMPO_W  clk cycles per beat, sampled on start
pause  in  1  level; freezes beat counter and window
rom_song  out  SONG_W  latched song select to ROM bank
rom_addr  out  ADDR_W  ROM read address
rom_data  in  NOTE_W  ROM data, valid exactly 1 cycle after rom_addr
window_out  out  NOTE_W*WINDOW  slot 0 in LSBs (current note), slot WINDOW-1 in MSBs (newest)
beat  out  1  one-cycle pulse on each window shift
note_index  out  ADDR_W  notes inserted since start
busy  out  1  high in FETCH/WAIT_BEAT/DRAIN
song_done  out  1  high while slot 0 == END_CODE and in DONE

Behaviour:
- Reset (async): state IDLE; all slots REST_CODE; rom_addr, rom_song, note_index, beat counter 0; beat, busy, song_done 0; end_seen 0.
- Tempo: latched period P = max(tempo_in, 4). Counter 0..P-1; beat fires the cycle counter == P-1, then wraps to 0. Counter cleared on start.
- States: IDLE, FETCH, WAIT_BEAT, DRAIN, DONE.
- start (any state, incl. mid-song): next cycle slots = REST_CODE, rom_addr = 0, note_index = 0, end_seen = 0, song_done = 0, state FETCH. start beats a coincident beat (no shift that cycle).
- FETCH: rom_addr presented; next cycle capture rom_data into prefetch reg, rom_addr +1, go WAIT_BEAT. Fetch is 2 cycles, always completes before next beat since P >= 4.
- WAIT_BEAT on beat: slot[i] <= slot[i+1] for i < WINDOW-1; slot[WINDOW-1] <= prefetch; note_index +1. If prefetch == END_CODE, end_seen = 1 and go DRAIN; else FETCH.
- Address wrap: if captured address was 2^ADDR_W-1 and data != END_CODE, prefetch forced to END_CODE (no silent wrap).
- DRAIN on beat: shift, insert REST_CODE; no ROM reads; note_index holds. When END_CODE reaches slot 0 go DONE.
- DONE: counter frozen, window frozen, beat 0, song_done 1, busy 0; leaves only on start or reset.
- pause=1: beat counter holds, beat suppressed; an in-progress FETCH still completes. Releasing pause resumes count from held value.
- beat output = internal beat gated by state in {WAIT_BEAT, DRAIN} and !pause.

Optional Feature:
Macro SCORE_LOOP_EN. Defined: adds input loop (level) and output loop_count [7:0] (reset 0, saturates at 255). When an END_CODE prefetch is shifted in with loop=1: REST_CODE inserted instead, rom_addr reset to 0, note_index reset to 0, loop_count +1, state FETCH (song repeats seamlessly, one rest gap). loop=0 behaves as baseline. Undefined: ports absent, END_CODE always enters DRAIN.

Test Plan:
- Reset mid-song with tempo_in=10: assert reset async between edges -> window_out all 0, rom_addr 0, busy 0 immediately.
- start, song_id=2, tempo_in=10, ROM notes 1,2,3,F -> beats every 10 cycles; after 4 beats slot15..12 = F,3,2,1; song_done rises exactly when F reaches slot 0 (beat 16+3), then beat stops.
- tempo_in=1 -> clamped, beat period 4 cycles.
- pause held 25 cycles mid-song -> no beat, window unchanged; next beat arrives at remaining count after release.
- Song with no END_CODE, ADDR_W=3 -> after 8 notes, END_CODE forced into slot 15, no repeat of address 0 data.
- SCORE_LOOP_EN, loop=1, ROM 1,2,F -> slot sequence 1,2,0,1,2,0; loop_count increments to 2 after two passes; song_done never asserts.
